// File: rtl/seq_detect_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// default sizing, FSM state encoding and the pattern-length mask helper.
package seq_detect_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    // Widest pattern any instance may be built for; the mask helper works at this width.
    localparam int MASK_W_MAX  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Mask with the low 'len' bits set (len = 0 gives all zeros, len = 16 all ones).
    function automatic logic [MASK_W_MAX-1:0] len_mask(input logic [4:0] len);
        logic [MASK_W_MAX:0] w_one_hot;
        w_one_hot = (MASK_W_MAX+1)'(1) << len;
        return MASK_W_MAX'(w_one_hot - (MASK_W_MAX+1)'(1));
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_core.sv
// seq_match_core: history shift register, fill counter and length-masked
// comparator. The match is combinational so the final bit of a pattern is
// flagged in the same cycle it is presented on i_x.
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter  int MAX_LEN = MAX_LEN_DEF,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_shift_en,
    input  logic               i_clear,
    input  logic               i_overlap,
    input  logic               i_x,
    input  logic [MAX_LEN-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0]   i_cfg_len,
    output logic               o_match
);

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;

    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_fill_ok;

    // The newest bit sits at position 0, matching the pattern's "last bit" end.
    assign w_window  = {r_hist[MAX_LEN-2:0], i_x};
    assign w_mask    = MAX_LEN'(len_mask(5'(i_cfg_len)));

    // Enough usable bits once the current one is counted; done one bit wider
    // so fill = MAX_LEN cannot wrap.
    assign w_fill_ok = ((LEN_W+1)'(r_fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(i_cfg_len);

    assign o_match   = i_shift_en && w_fill_ok &&
                       (((w_window ^ i_cfg_pattern) & w_mask) == '0);

    // Shift in sampled bits and track how many of them may still form a match.
    always_ff @(posedge i_clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // in this block sees the pre-edge values of the others.
        if (i_rst || i_clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift_en) begin
            r_hist <= w_window;
            if (o_match && !i_overlap) begin
                // Non-overlapping: bits consumed by a match never seed the next one.
                r_fill <= '0;
            end else if (r_fill != LEN_W'(MAX_LEN)) begin
                r_fill <= r_fill + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run-time programmable serial pattern detector.
// Holds the configuration registers, the IDLE/RUN/DONE sequencing FSM and
// the saturating match counter; bit matching lives in seq_match_core.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter  int MAX_LEN = MAX_LEN_DEF,
    parameter  int CNT_W   = CNT_W_DEF,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [MAX_LEN-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0]   i_cfg_len,
    input  logic               i_cfg_overlap,
    input  logic [CNT_W-1:0]   i_cfg_target,
    output logic               o_cfg_err,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_x,
    input  logic               i_x_valid,
    output logic               o_z,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_match_count
);

    state_t r_state;
    state_t w_next_state;

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_target;
    logic               r_configured;
    logic               r_cfg_err;
    logic [CNT_W-1:0]   r_count;

    logic               w_run;
    logic               w_len_ok;
    logic               w_cfg_accept;
    logic               w_cfg_reject;
    logic               w_start_ok;
    logic               w_shift_en;
    logic               w_core_clear;
    logic               w_match;
    logic [CNT_W:0]     w_count_inc;
    logic               w_count_sat;
    logic               w_terminal;

    assign w_run        = (r_state == ST_RUN);
    assign w_len_ok     = (i_cfg_len != '0) && (i_cfg_len <= LEN_W'(MAX_LEN));
    assign w_cfg_accept = i_cfg_valid && !w_run && w_len_ok;
    assign w_cfg_reject = i_cfg_valid && !w_run && !w_len_ok;

    // A config written on the same edge as start is enough to make the run legal.
    assign w_start_ok   = i_start && !i_stop && !w_run && (r_configured || w_cfg_accept);

    assign w_shift_en   = w_run && i_x_valid;
    assign w_core_clear = w_start_ok || (w_run && i_stop);

    // Terminal check is done one bit wider so a saturated counter cannot wrap.
    assign w_count_inc  = (CNT_W+1)'(r_count) + (CNT_W+1)'(1);
    assign w_count_sat  = &r_count;
    assign w_terminal   = w_match && (r_target != '0) &&
                          ((w_count_inc == (CNT_W+1)'(r_target)) || (r_count >= r_target));

    seq_match_core #(
        .MAX_LEN (MAX_LEN)
    ) u_core (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_shift_en    (w_shift_en),
        .i_clear       (w_core_clear),
        .i_overlap     (r_overlap),
        .i_x           (i_x),
        .i_cfg_pattern (r_pattern),
        .i_cfg_len     (r_len),
        .o_match       (w_match)
    );

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; stop always wins over start.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned
        // and no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (i_stop)          w_next_state = ST_IDLE;
                else if (w_terminal) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (i_stop)          w_next_state = ST_IDLE;
                else if (w_start_ok) w_next_state = ST_RUN;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_cfg_ready = 1'b1;
        unique case (r_state)
            ST_RUN:  begin
                o_busy      = 1'b1;
                o_cfg_ready = 1'b0;
            end
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    // Configuration registers: only a legal length overwrites the stored config.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pattern    <= '0;
            r_len        <= '0;
            r_overlap    <= 1'b0;
            r_target     <= '0;
            r_configured <= 1'b0;
        end else if (w_cfg_accept) begin
            r_pattern    <= i_cfg_pattern;
            r_len        <= i_cfg_len;
            r_overlap    <= i_cfg_overlap;
            r_target     <= i_cfg_target;
            r_configured <= 1'b1;
        end
    end

    // One-cycle error pulse for a rejected config write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_reject;
        end
    end

    // Saturating match counter, cleared on run start and held across stop.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_start_ok) begin
            r_count <= '0;
        end else if (w_run && !i_stop && w_match && !w_count_sat) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_z           = w_match;
    assign o_cfg_err     = r_cfg_err;
    assign o_match_count = r_count;

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Run-time programmable controller for a serial bit-pattern detector, generalising the fixed Mealy detectors (e.g. 101, 11101) into one configurable, sequenced block.
- Config port loads the pattern, its length, overlap mode and a match target.
- start/stop sequence the detection run. Match output is a Mealy pulse, and a saturating match counter is kept.
- Sits between the serial input lane and the status/interrupt logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..16).
- CNT_W, 8, width of the match counter and target.
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived, not overridden).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  high when config is accepted (state IDLE or DONE).
- cfg_pattern  in  MAX_LEN  pattern. Bit [cfg_len-1] is the first bit received, bit 0 the last. Bits above cfg_len-1 are ignored.
- cfg_len  in  LEN_W  pattern length, legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_target  in  CNT_W  number of matches that ends the run. 0 = unlimited.
- cfg_err  out  1  one-cycle pulse when a config write is rejected.
- start  in  1  begin a run (IDLE or DONE only, and only when configured).
- stop  in  1  abort a run.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled this cycle.
- z  out  1  Mealy match pulse, combinational.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.
- match_count  out  CNT_W  matches in the current or last run, saturating.

Behaviour:
- Reset: state IDLE, configured=0, pattern/len/overlap/target = 0, history=0, fill=0, match_count=0, cfg_err=0. Outputs z=0, busy=0, done=0, cfg_ready=1.
- States: IDLE -> RUN on start && configured && !stop. RUN -> IDLE on stop. RUN -> DONE on the terminal match. DONE -> RUN on start. DONE -> IDLE on stop.
- start in IDLE/DONE clears match_count, history and fill on the same edge. start while unconfigured is ignored.
- Config accept: cfg_valid && cfg_ready && 1<=cfg_len<=MAX_LEN. Registers are loaded and configured is set.
- Config reject: cfg_valid && cfg_ready with an illegal len. cfg_err pulses the next cycle and the existing config is unchanged.
- cfg_valid while in RUN is ignored, with no error (cfg_ready=0).
- History: on each RUN cycle with x_valid, hist <= {hist[MAX_LEN-2:0], x}. fill increments and saturates at MAX_LEN.
- Match (combinational): RUN && x_valid && (fill+1 >= len) && ({hist,x} low len bits == pattern low len bits). z = match, in the same cycle as the final bit, with no register.
- On a match edge: match_count increments and saturates at all-ones.
- Non-overlap mode: fill is set to 0 on the match edge, so bits of a matched pattern are never reused. Overlap mode: fill continues.
- Terminal match: target != 0 and match_count+1 == target, or already saturated at >= target. State -> DONE on that edge, and z still pulses for it.
- x_valid=0 in RUN: no shift, no match, z=0.
- Simultaneous start and stop: stop wins and the state goes to IDLE.
- Simultaneous cfg_valid and start in IDLE/DONE: config is written, and the run starts with the new config. Matching uses the registered config, so the first sampled bit is on the next cycle anyway.
- stop mid-run: match_count is held for readout, and history/fill are cleared.
- rst mid-run: full reset to the values above, and the config is lost.

Decomposition:
- Package seq_detect_pkg: state encoding constants (ST_IDLE, ST_RUN, ST_DONE) and the MAX_LEN/CNT_W defaults.
- One sub-module, seq_match_core: history shift register, fill counter and length-masked comparator. Produces the match output. Inputs are shift_en, clear, overlap and cfg. The top holds the FSM, config registers and counter.

Test Plan:
- Config pattern=3'b101, len=3, overlap=0, target=0. start, then x=1,0,1,0,1 with x_valid=1 -> z=1 only during the 3rd bit. match_count=1 after the stream.
- Same stream with overlap=1 -> z=1 during the 3rd and 5th bits. match_count=2.
- Pattern 4'b1010, len=4, non-overlap, target=2. Stream 1,0,1,0,1,0,1,0 -> z pulses during bits 4 and 8. done=1 and busy=0 after bit 8, and further bits give z=0.
- cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err pulses once for each. start after the rejects is ignored while unconfigured (busy=0). A cfg_valid during RUN has no effect.
- Run pattern 101. Assert start and stop together -> IDLE. Stop after bits 1,0 and restart, then feed 1 -> no match, because history was cleared.
- rst asserted mid-run after bits 1,0 -> next cycle: busy=0, match_count=0, cfg_ready=1. start is ignored until reconfigured.
